// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM arbiter definitions: controller command encoding, FSM states
// and default burst/timeout figures used by the arbiter and its requesters.
package sdram_arbiter_pkg;

    localparam int ADDR_W              = 22;
    localparam int WORD_W              = 32;
    localparam int DEFAULT_READ_BURST  = 8;
    localparam int DEFAULT_WRITE_BURST = 8;
    localparam int DEFAULT_TIMEOUT     = 255;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } sdram_cmd_t;

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_RD_CMD,
        S_RD_BURST,
        S_WR_CMD,
        S_WR_BURST
    } arb_state_t;

    // One spare bit so the count can reach the full burst length.
    function automatic int beat_cnt_width(input int rd_len, input int wr_len);
        return $clog2((rd_len > wr_len) ? rd_len : wr_len) + 1;
    endfunction

endpackage

// File: rtl/sdram_arbiter_watchdog.sv
// Loadable down-counter: reloads to TIMEOUT on load, counts down to zero and
// flags expiry while it sits at zero.
module sdram_arbiter_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller command port between the display read path and
// the render write path, one whole burst at a time.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int READ_BURST_LENGTH  = DEFAULT_READ_BURST,
    parameter int WRITE_BURST_LENGTH = DEFAULT_WRITE_BURST,
    parameter int TIMEOUT            = DEFAULT_TIMEOUT
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Init_Complete,
    input  logic              i_Rd_Req,
    input  logic              i_Rd_Urgent,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic              o_Rd_Grant,
    output logic              o_Rd_Valid,
    output logic [WORD_W-1:0] o_Rd_Data,
    output logic              o_Rd_Done,
    input  logic              i_Wr_Req,
    input  logic [ADDR_W-1:0] i_Wr_Addr,
    input  logic [WORD_W-1:0] i_Wr_Data,
    output logic              o_Wr_Grant,
    output logic              o_Wr_Next,
    output logic              o_Wr_Done,
    output logic [1:0]        o_Command,
    output logic [ADDR_W-1:0] o_Data_Address,
    output logic [WORD_W-1:0] o_Data_Write,
    input  logic              i_Data_Read_Valid,
    input  logic              i_Data_Write_Done,
    input  logic [WORD_W-1:0] i_Data_Read,
    output logic              o_Error
);

    localparam int                CNT_W  = beat_cnt_width(READ_BURST_LENGTH, WRITE_BURST_LENGTH);
    localparam logic [CNT_W-1:0] RD_LEN = CNT_W'(READ_BURST_LENGTH);
    localparam logic [CNT_W-1:0] WR_LEN = CNT_W'(WRITE_BURST_LENGTH);

    arb_state_t        state, state_nxt;
    logic              last_wr, last_wr_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt, beat_inc;
    logic [ADDR_W-1:0] addr_nxt;
    logic              rd_grant_nxt, wr_grant_nxt, rd_done_nxt, wr_done_nxt, error_nxt;
    logic              rd_pick, in_rd, in_wr;
    logic              wd_load, wd_expired;

    sdram_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (i_Clk),
        .rst     (i_Reset),
        .load    (wd_load),
        .expired (wd_expired)
    );

    assign in_rd    = (state == S_RD_CMD) || (state == S_RD_BURST);
    assign in_wr    = (state == S_WR_CMD) || (state == S_WR_BURST);
    assign beat_inc = beat_cnt + 1'b1;
    // Urgent reads always win; under contention the side not served last goes.
    assign rd_pick  = i_Rd_Req && (i_Rd_Urgent || !i_Wr_Req || last_wr);

    always_comb begin
        state_nxt    = state;
        last_wr_nxt  = last_wr;
        beat_cnt_nxt = beat_cnt;
        addr_nxt     = o_Data_Address;
        rd_grant_nxt = 1'b0;
        wr_grant_nxt = 1'b0;
        rd_done_nxt  = 1'b0;
        wr_done_nxt  = 1'b0;
        error_nxt    = o_Error;
        wd_load      = 1'b0;
        case (state)
            S_WAIT_INIT: begin
                wd_load = 1'b1;
                if (i_Init_Complete) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                wd_load = 1'b1;
                if (i_Data_Read_Valid || i_Data_Write_Done) error_nxt = 1'b1;
                if (rd_pick) begin
                    addr_nxt     = i_Rd_Addr;
                    rd_grant_nxt = 1'b1;
                    beat_cnt_nxt = '0;
                    state_nxt    = S_RD_CMD;
                end else if (i_Wr_Req) begin
                    addr_nxt     = i_Wr_Addr;
                    wr_grant_nxt = 1'b1;
                    beat_cnt_nxt = '0;
                    state_nxt    = S_WR_CMD;
                end
            end
            S_RD_CMD, S_RD_BURST: begin
                if (i_Data_Write_Done) error_nxt = 1'b1;
                if (i_Data_Read_Valid) begin
                    wd_load      = 1'b1;
                    beat_cnt_nxt = beat_inc;
                    state_nxt    = S_RD_BURST;
                    if (beat_inc == RD_LEN) begin
                        rd_done_nxt = 1'b1;
                        last_wr_nxt = 1'b0;
                        state_nxt   = S_IDLE;
                    end
                end else if (wd_expired) begin
                    error_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WR_CMD, S_WR_BURST: begin
                if (i_Data_Read_Valid) error_nxt = 1'b1;
                if (i_Data_Write_Done) begin
                    wd_load      = 1'b1;
                    beat_cnt_nxt = beat_inc;
                    state_nxt    = S_WR_BURST;
                    if (beat_inc == WR_LEN) begin
                        wr_done_nxt = 1'b1;
                        last_wr_nxt = 1'b1;
                        state_nxt   = S_IDLE;
                    end
                end else if (wd_expired) begin
                    error_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_WAIT_INIT;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state          <= S_WAIT_INIT;
            last_wr        <= 1'b1;
            beat_cnt       <= '0;
            o_Data_Address <= '0;
            o_Rd_Grant     <= 1'b0;
            o_Wr_Grant     <= 1'b0;
            o_Rd_Done      <= 1'b0;
            o_Wr_Done      <= 1'b0;
            o_Error        <= 1'b0;
        end else begin
            state          <= state_nxt;
            last_wr        <= last_wr_nxt;
            beat_cnt       <= beat_cnt_nxt;
            o_Data_Address <= addr_nxt;
            o_Rd_Grant     <= rd_grant_nxt;
            o_Wr_Grant     <= wr_grant_nxt;
            o_Rd_Done      <= rd_done_nxt;
            o_Wr_Done      <= wr_done_nxt;
            o_Error        <= error_nxt;
        end
    end

    // The command stays asserted until the first beat moves the FSM into BURST.
    assign o_Command    = (state == S_RD_CMD) ? CMD_READ :
                          (state == S_WR_CMD) ? CMD_WRITE : CMD_NOP;
    assign o_Rd_Valid   = i_Data_Read_Valid && in_rd;
    assign o_Rd_Data    = i_Data_Read;
    assign o_Wr_Next    = i_Data_Write_Done && in_wr;
    assign o_Data_Write = in_wr ? i_Wr_Data : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter: plays both requesters and the SDRAM
// controller, predicting grants and beats from a transaction-level model.
module tb_sdram_arbiter;

    localparam int RL = 8;
    localparam int WL = 8;
    localparam int TO = 16;

    logic        i_Clk = 1'b0;
    logic        i_Reset, i_Init_Complete;
    logic        i_Rd_Req, i_Rd_Urgent, i_Wr_Req;
    logic [21:0] i_Rd_Addr, i_Wr_Addr;
    logic [31:0] i_Wr_Data, i_Data_Read;
    logic        i_Data_Read_Valid, i_Data_Write_Done;
    logic        o_Rd_Grant, o_Rd_Valid, o_Rd_Done;
    logic        o_Wr_Grant, o_Wr_Next, o_Wr_Done, o_Error;
    logic [31:0] o_Rd_Data, o_Data_Write;
    logic [21:0] o_Data_Address;
    logic [1:0]  o_Command;

    always #5 i_Clk = ~i_Clk;

    sdram_arbiter #(
        .READ_BURST_LENGTH  (RL),
        .WRITE_BURST_LENGTH (WL),
        .TIMEOUT            (TO)
    ) dut (
        .i_Clk             (i_Clk),
        .i_Reset           (i_Reset),
        .i_Init_Complete   (i_Init_Complete),
        .i_Rd_Req          (i_Rd_Req),
        .i_Rd_Urgent       (i_Rd_Urgent),
        .i_Rd_Addr         (i_Rd_Addr),
        .o_Rd_Grant        (o_Rd_Grant),
        .o_Rd_Valid        (o_Rd_Valid),
        .o_Rd_Data         (o_Rd_Data),
        .o_Rd_Done         (o_Rd_Done),
        .i_Wr_Req          (i_Wr_Req),
        .i_Wr_Addr         (i_Wr_Addr),
        .i_Wr_Data         (i_Wr_Data),
        .o_Wr_Grant        (o_Wr_Grant),
        .o_Wr_Next         (o_Wr_Next),
        .o_Wr_Done         (o_Wr_Done),
        .o_Command         (o_Command),
        .o_Data_Address    (o_Data_Address),
        .o_Data_Write      (o_Data_Write),
        .i_Data_Read_Valid (i_Data_Read_Valid),
        .i_Data_Write_Done (i_Data_Write_Done),
        .i_Data_Read       (i_Data_Read),
        .o_Error           (o_Error)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit last_w;   // model: most recently completed burst was a write
    bit exp_err;  // model: sticky error expected

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic expect_grant(input bit rd, input logic [21:0] addr);
        check("rd_grant", 64'(o_Rd_Grant), 64'(rd));
        check("wr_grant", 64'(o_Wr_Grant), 64'(!rd));
        check("grant_cmd", 64'(o_Command), rd ? 64'd1 : 64'd2);
        check("grant_addr", 64'(o_Data_Address), 64'(addr));
        check("grant_no_done", 64'(o_Rd_Done | o_Wr_Done), 64'd0);
    endtask

    // Controller side of one burst; ends in the cycle where Done is expected.
    task automatic burst(input bit rd, input bit seq);
        logic [31:0] w [WL];
        logic [31:0] d;
        logic [63:0] cmd;
        int          n;
        int          gap;
        n   = rd ? RL : WL;
        cmd = rd ? 64'd1 : 64'd2;
        for (int b = 0; b < WL; b++) w[b] = seq ? 32'hA0 + 32'(b) : $urandom;
        for (int b = 0; b < n; b++) begin
            gap = seq ? 0 : int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                i_Data_Read_Valid = 1'b0;
                i_Data_Write_Done = 1'b0;
                if (!rd) i_Wr_Data = w[b];
                #1;
                check("gap_cmd", 64'(o_Command), (b == 0) ? cmd : 64'd0);
                check("gap_strobe", 64'(o_Rd_Valid | o_Wr_Next), 64'd0);
                if (!rd) check("gap_wr_data", 64'(o_Data_Write), 64'(w[b]));
                check("gap_done", 64'(o_Rd_Done | o_Wr_Done), 64'd0);
                tick();
            end
            d = seq ? 32'(b) : $urandom;
            if (rd) begin
                i_Data_Read_Valid = 1'b1;
                i_Data_Read       = d;
            end else begin
                i_Data_Write_Done = 1'b1;
                i_Wr_Data         = w[b];
            end
            #1;
            check("beat_cmd", 64'(o_Command), (b == 0) ? cmd : 64'd0);
            if (rd) begin
                check("rd_valid", 64'(o_Rd_Valid), 64'd1);
                check("rd_data", 64'(o_Rd_Data), 64'(d));
            end else begin
                check("wr_next", 64'(o_Wr_Next), 64'd1);
                check("wr_data", 64'(o_Data_Write), 64'(w[b]));
            end
            check("beat_no_done", 64'(o_Rd_Done | o_Wr_Done), 64'd0);
            tick();
        end
        i_Data_Read_Valid = 1'b0;
        i_Data_Write_Done = 1'b0;
        #1;
        check("rd_done", 64'(o_Rd_Done), 64'(rd));
        check("wr_done", 64'(o_Wr_Done), 64'(!rd));
        check("done_cmd", 64'(o_Command), 64'd0);
        check("idle_wr_data", 64'(o_Data_Write), 64'd0);
        check("error", 64'(o_Error), 64'(exp_err));
        last_w = !rd;
    endtask

    // Present requests in an IDLE cycle, check the arbitration outcome, run the burst.
    task automatic transaction(input bit rq, input bit wq, input bit urg, input bit seq,
                               input logic [21:0] ra, input logic [21:0] wa);
        bit exp_rd;
        exp_rd      = rq && (urg || !wq || last_w);
        i_Rd_Req    = rq;
        i_Wr_Req    = wq;
        i_Rd_Urgent = urg;
        i_Rd_Addr   = ra;
        i_Wr_Addr   = wa;
        tick();
        expect_grant(exp_rd, exp_rd ? ra : wa);
        i_Rd_Req    = 1'b0;
        i_Wr_Req    = 1'b0;
        i_Rd_Urgent = 1'b0;
        i_Rd_Addr   = 22'($urandom);
        i_Wr_Addr   = 22'($urandom);
        burst(exp_rd, seq);
    endtask

    initial begin
        #500000;
        $display("FAIL sim_timeout: simulation exceeded its time bound");
        $fatal(1);
    end

    initial begin
        bit          rq, wq;
        logic [21:0] ta;
        i_Reset = 1'b1; i_Init_Complete = 1'b0;
        i_Rd_Req = 1'b0; i_Rd_Urgent = 1'b0; i_Wr_Req = 1'b0;
        i_Rd_Addr = '0; i_Wr_Addr = '0; i_Wr_Data = '0; i_Data_Read = '0;
        i_Data_Read_Valid = 1'b0; i_Data_Write_Done = 1'b0;
        last_w  = 1'b1;
        exp_err = 1'b0;
        repeat (3) tick();
        check("rst_cmd", 64'(o_Command), 64'd0);
        check("rst_addr", 64'(o_Data_Address), 64'd0);
        check("rst_wdata", 64'(o_Data_Write), 64'd0);
        check("rst_error", 64'(o_Error), 64'd0);
        check("rst_strobes", 64'({o_Rd_Grant, o_Wr_Grant, o_Rd_Done, o_Wr_Done, o_Rd_Valid, o_Wr_Next}), 64'd0);

        // Init gating: request waits until the controller is initialised.
        i_Reset   = 1'b0;
        i_Rd_Req  = 1'b1;
        i_Rd_Addr = 22'h00ABC;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("init_gate_grant", 64'(o_Rd_Grant), 64'd0);
            check("init_gate_cmd", 64'(o_Command), 64'd0);
        end
        i_Init_Complete = 1'b1;
        tick();
        check("init_idle_grant", 64'(o_Rd_Grant), 64'd0);
        tick();
        expect_grant(1'b1, 22'h00ABC);
        i_Rd_Req = 1'b0;
        burst(1'b1, 1'b1);

        transaction(1'b0, 1'b1, 1'b0, 1'b1, 22'h0, 22'h01234);
        repeat (4) transaction(1'b1, 1'b1, 1'b0, 1'b0, 22'($urandom), 22'($urandom));
        repeat (3) transaction(1'b1, 1'b1, 1'b1, 1'b0, 22'($urandom), 22'($urandom));
        repeat (40) begin
            rq = 1'($urandom);
            wq = 1'($urandom);
            if (!rq && !wq) rq = 1'b1;
            transaction(rq, wq, 1'($urandom), 1'b0, 22'($urandom), 22'($urandom));
        end

        // Watchdog: a granted read with no beats is abandoned.
        ta        = 22'($urandom);
        i_Rd_Req  = 1'b1;
        i_Rd_Addr = ta;
        tick();
        expect_grant(1'b1, ta);
        i_Rd_Req = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            tick();
            check("to_error_early", 64'(o_Error), 64'd0);
            check("to_cmd_held", 64'(o_Command), 64'd1);
        end
        tick();
        exp_err = 1'b1;
        check("to_error", 64'(o_Error), 64'd1);
        check("to_cmd_nop", 64'(o_Command), 64'd0);
        check("to_no_done", 64'(o_Rd_Done), 64'd0);
        ta        = 22'($urandom);
        i_Wr_Req  = 1'b1;
        i_Wr_Addr = ta;
        tick();
        expect_grant(1'b0, ta);
        i_Wr_Req = 1'b0;
        burst(1'b0, 1'b0);

        // Reset in the middle of a write burst.
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        last_w  = 1'b1;
        exp_err = 1'b0;
        check("rst2_error", 64'(o_Error), 64'd0);
        tick();
        ta        = 22'($urandom);
        i_Wr_Req  = 1'b1;
        i_Wr_Addr = ta;
        tick();
        expect_grant(1'b0, ta);
        i_Wr_Req = 1'b0;
        for (int b = 0; b < 4; b++) begin
            i_Wr_Data         = 32'hA0 + 32'(b);
            i_Data_Write_Done = 1'b1;
            tick();
        end
        i_Data_Write_Done = 1'b0;
        i_Reset           = 1'b1;
        i_Init_Complete   = 1'b0;
        tick();
        check("midrst_cmd", 64'(o_Command), 64'd0);
        check("midrst_no_done", 64'(o_Wr_Done), 64'd0);
        check("midrst_error", 64'(o_Error), 64'd0);
        i_Reset           = 1'b0;
        i_Wr_Req          = 1'b1;
        i_Data_Write_Done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("wait_init_grant", 64'(o_Wr_Grant), 64'd0);
            check("wait_init_cmd", 64'(o_Command), 64'd0);
            check("wait_init_error", 64'(o_Error), 64'd0);
        end

        // Stray beat in IDLE is flagged and not forwarded.
        i_Wr_Req          = 1'b0;
        i_Data_Write_Done = 1'b0;
        i_Init_Complete   = 1'b1;
        tick();
        i_Data_Read_Valid = 1'b1;
        #1;
        check("stray_not_fwd", 64'(o_Rd_Valid), 64'd0);
        tick();
        i_Data_Read_Valid = 1'b0;
        check("stray_error", 64'(o_Error), 64'd1);
        tick();
        check("error_sticky", 64'(o_Error), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Arbitrates the single SDRAM controller command port between two requesters: the display read path (frame reader filling the pixel FIFO) and the render write path (Julia engine storing computed pixels). It sits on the memory clock between the requesters and the SDRAM controller. It serialises whole bursts, counts response beats, and returns data and completion strobes to the owning requester. Display reads win when flagged urgent; otherwise grants alternate.

## Interface
Parameters:
- READ_BURST_LENGTH, 8, words returned per read command
- WRITE_BURST_LENGTH, 8, words consumed per write command
- TIMEOUT, 255, max cycles between beats before a burst is abandoned

Ports:
- i_Clk  in  1  memory clock; sole clock
- i_Reset  in  1  synchronous, active-high reset
- i_Init_Complete  in  1  SDRAM controller initialisation finished
- i_Rd_Req  in  1  read requester wants a burst
- i_Rd_Urgent  in  1  pixel FIFO below low-water mark
- i_Rd_Addr  in  22  read burst start address
- o_Rd_Grant  out  1  1-cycle pulse: read burst accepted
- o_Rd_Valid  out  1  o_Rd_Data holds a beat
- o_Rd_Data  out  32  read beat
- o_Rd_Done  out  1  1-cycle pulse after final read beat
- i_Wr_Req  in  1  write requester wants a burst
- i_Wr_Addr  in  22  write burst start address
- i_Wr_Data  in  32  current write word
- o_Wr_Grant  out  1  1-cycle pulse: write burst accepted
- o_Wr_Next  out  1  current word consumed; present next word
- o_Wr_Done  out  1  1-cycle pulse after final write beat
- o_Command  out  2  to controller: NOP/READ/WRITE
- o_Data_Address  out  22  to controller
- o_Data_Write  out  32  to controller
- i_Data_Read_Valid  in  1  controller read beat strobe
- i_Data_Write_Done  in  1  controller write beat strobe
- i_Data_Read  in  32  controller read data
- o_Error  out  1  sticky: timeout or stray beat seen

## Operation
- States: WAIT_INIT, IDLE, RD_CMD, RD_BURST, WR_CMD, WR_BURST.
- WAIT_INIT: all outputs idle. Move to IDLE on i_Init_Complete.
- IDLE arbitration, evaluated each cycle:
  - i_Rd_Req & i_Rd_Urgent → read.
  - Else both requesting → the one not granted last (reset: read).
  - Else the single requester.
  - Else stay.
- On grant: latch the address into o_Data_Address, pulse the grant, and enter RD_CMD or WR_CMD.
- RD_CMD / WR_CMD: hold o_Command = READ/WRITE until the first beat strobe arrives. That beat counts as beat 0. Then go to RD_BURST / WR_BURST with o_Command = NOP.
- Beat counter: width $clog2(max burst)+1; cleared on grant and incremented per beat strobe. When the count reaches the burst length: pulse Done, update last-granted, return to IDLE.
- Read path:
  - o_Rd_Valid = i_Data_Read_Valid while in RD_CMD/RD_BURST.
  - o_Rd_Data = i_Data_Read, combinational passthrough.
- Write path:
  - o_Data_Write = i_Wr_Data in WR_CMD/WR_BURST, else 0.
  - o_Wr_Next = i_Data_Write_Done in those states.
  - The requester holds word 0 from the grant and advances the cycle after each o_Wr_Next.
- Timeout: a watchdog counter resets on every beat or grant. If it reaches TIMEOUT in any CMD/BURST state: set o_Error, force NOP, go to IDLE, and issue no Done.
- Stray beat (either strobe in IDLE, or the wrong-type strobe during a burst): set o_Error, ignore the beat.
- o_Error clears only on reset.
- Command encoding NOP=2'd0, READ=2'd1, WRITE=2'd2; 2'd3 is never driven.

## Timing
- Reset values:
  - state WAIT_INIT; o_Command NOP; o_Data_Address 0; o_Data_Write 0; o_Error 0.
  - All grant, valid, next and done strobes 0; last-granted = write, so the first contended grant goes to read.
- Latency: request seen in IDLE at cycle N → grant pulse and o_Command asserted at N+1.
- Done pulses the cycle after the final beat strobe.
- Minimum gap Done → next grant: 1 cycle (the IDLE cycle).
- A request dropped after grant has no effect; the burst completes.
- Requests arriving mid-burst are held pending; requesters must keep Req high until their grant.
- Reset mid-burst: immediate return to WAIT_INIT with NOP on the next edge. Any in-flight controller beats after reset are stray and set o_Error only once i_Init_Complete is re-qualified.

## Structure
- Command encodings and burst-length defaults live in the shared sdram.vh header, also used by the frame reader and controller.
- One sub-module, sdram_arb_watchdog: a loadable down-counter with an expiry flag. All other logic is the single FSM module.

## Test plan
- Init gating: i_Rd_Req high before i_Init_Complete → no grant. i_Init_Complete at cycle 10 → o_Rd_Grant at cycle 12, o_Command=1 with the latched address 0x00ABC.
- Read burst: 8 i_Data_Read_Valid beats with data 0..7 → o_Rd_Valid/o_Rd_Data mirror them, o_Command returns to 0 after beat 0, and o_Rd_Done pulses once, one cycle after beat 7.
- Write burst: 8 i_Data_Write_Done beats → 8 o_Wr_Next pulses, o_Data_Write tracks i_Wr_Data words 0xA0..0xA7, then o_Wr_Done.
- Arbitration: both requesting continuously with urgent=0 → grants alternate R,W,R,W. Raise i_Rd_Urgent → consecutive read grants.
- Timeout: TIMEOUT=16, grant read and supply no beats → o_Error set at cycle 17 after grant, FSM in IDLE, no o_Rd_Done.
- Reset mid-write after beat 3 → NOP next cycle, state WAIT_INIT, no o_Wr_Done, o_Error 0.
